// File: rtl/lsu_ram_bridge_pkg.sv
// Shared definitions for the load/store RAM bridge: access size encodings,
// bridge FSM states, captured-request payload and the clogb2 helper that the
// RAM also uses to size its address port.
package lsu_ram_bridge_pkg;

    // Access size encodings carried on req_size.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC2 = 2'd1,
        ST_RDW  = 2'd2,
        ST_RSP  = 2'd3
    } lsu_state_e;

    // Request fields kept past the accept cycle for load alignment.
    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
        logic       uns;
    } lsu_req_meta_t;

    // Number of bits needed to represent value (clogb2(2047) = 11).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v != 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

    // Unshifted byte-lane mask for an access size; illegal size gives no lanes.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 4'b0001;
            SIZE_H:  return 4'b0011;
            SIZE_W:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ram_bridge_load_align.sv
// lsu_load_align: combinational load data shift and extend.
//   hi, lo   : second and first RAM words of the access ({hi, lo} window)
//   offset   : byte offset of the access within lo
//   size     : SIZE_B / SIZE_H / SIZE_W
//   uns      : 1 = zero-extend, 0 = sign-extend
//   rdata_c  : right-aligned, extended load data
module lsu_load_align
    import lsu_ram_bridge_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata_c
);

    logic [31:0] word_c;

    // Only the low word of the shifted 64-bit window is ever needed.
    assign word_c = 32'({hi, lo} >> {offset, 3'b000});

    always_comb begin
        rdata_c = word_c;
        case (size)
            SIZE_B:  rdata_c = {{24{~uns & word_c[7]}}, word_c[7:0]};
            SIZE_H:  rdata_c = {{16{~uns & word_c[15]}}, word_c[15:0]};
            default: rdata_c = word_c;
        endcase
    end

endmodule

// File: rtl/lsu_ram_bridge.sv
// lsu_ram_bridge: byte-addressed valid/ready load/store requests to word-indexed
// RAM port B accesses, with a held response register for load data.
//   clk, rst_n                      : clock, async active-low reset
//   req_valid/req_ready             : request handshake
//   req_we/addr/size/unsigned/wdata : request payload
//   rsp_valid/rsp_ready             : response handshake
//   rsp_rdata/rsp_err               : extended load data, access fault
//   ram_en/we/wem/addr/din, ram_dout: RAM port B (one-cycle read latency)
// Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into
// two consecutive word accesses; otherwise misaligned accesses fault.
// ram_* and req_ready are combinational so the RAM sees the access in the
// accept cycle itself.
module lsu_ram_bridge
    import lsu_ram_bridge_pkg::*;
#(
    parameter int unsigned RAM_DEPTH = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned AW = clogb2(RAM_DEPTH - 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          ram_en,
    output logic          ram_we,
    output logic [3:0]    ram_wem,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    lsu_state_e    state_q, state_d;
    lsu_req_meta_t meta_q;

    logic          accept;
    logic [1:0]    off;
    logic [31:0]   rel;
    logic [31:0]   widx;
    logic [3:0]    lane_m;
    logic          misal;
    logic          acc_err;
    logic          rsp_load;
    logic          rsp_err_d;
    logic [31:0]   rsp_rdata_d;
    logic [31:0]   align_hi;
    logic [31:0]   align_lo;
    logic [31:0]   align_rdata_c;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [7:0]    sh_mask;
    logic [63:0]   sh_data;
    logic          split_oob;
    logic          split_q;
    logic          we_q;
    logic [AW-1:0] w1_q;
    logic [3:0]    wem_hi_q;
    logic [31:0]   din_hi_q;
    logic [31:0]   lo_q;
`else
    logic [3:0]    sh_mask;
    logic [31:0]   sh_data;
`endif

    // Request decode: word index, lanes, alignment and fault detection.
    assign req_ready = (state_q == ST_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign off       = req_addr[1:0];
    assign rel       = req_addr - BASE_ADDR;
    assign widx      = rel >> 2;
    assign lane_m    = size_mask(req_size);
    assign misal     = ((req_size == SIZE_W) && (off != 2'd0)) ||
                       ((req_size == SIZE_H) && (off == 2'd3));

`ifdef LSU_MISALIGN_SPLIT_EN
    assign sh_mask   = {4'b0000, lane_m} << off;
    assign sh_data   = {32'h0, req_wdata} << {off, 3'b000};
    assign split_oob = (widx + 32'd1) >= 32'(RAM_DEPTH);
    assign acc_err   = (req_size == SIZE_X) || (widx >= 32'(RAM_DEPTH)) ||
                       (misal && split_oob);
    assign align_hi  = split_q ? ram_dout : 32'h0;
    assign align_lo  = split_q ? lo_q : ram_dout;
`else
    assign sh_mask   = lane_m << off;
    assign sh_data   = req_wdata << {off, 3'b000};
    assign acc_err   = (req_size == SIZE_X) || (widx >= 32'(RAM_DEPTH)) || misal;
    assign align_hi  = 32'h0;
    assign align_lo  = ram_dout;
`endif

    lsu_load_align u_load_align (
        .hi      (align_hi),
        .lo      (align_lo),
        .offset  (meta_q.off),
        .size    (meta_q.size),
        .uns     (meta_q.uns),
        .rdata_c (align_rdata_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, RAM port drive and response load.
    always_comb begin
        state_d     = state_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_wem     = 4'b0000;
        ram_addr    = '0;
        ram_din     = 32'h0;
        rsp_load    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (acc_err) begin
                        state_d   = ST_RSP;
                        rsp_load  = 1'b1;
                        rsp_err_d = 1'b1;
                    end else begin
                        ram_en   = 1'b1;
                        ram_we   = req_we;
                        ram_addr = widx[AW-1:0];
                        ram_wem  = sh_mask[3:0];
                        ram_din  = sh_data[31:0];
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (misal) begin
                            state_d = ST_ACC2;
                        end else
`endif
                        if (req_we) begin
                            state_d  = ST_RSP;
                            rsp_load = 1'b1;
                        end else begin
                            state_d = ST_RDW;
                        end
                    end
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ACC2: begin
                ram_en   = 1'b1;
                ram_we   = we_q;
                ram_addr = w1_q;
                ram_wem  = wem_hi_q;
                ram_din  = din_hi_q;
                if (we_q) begin
                    state_d  = ST_RSP;
                    rsp_load = 1'b1;
                end else begin
                    state_d = ST_RDW;
                end
            end
`endif
            ST_RDW: begin
                state_d     = ST_RSP;
                rsp_load    = 1'b1;
                rsp_rdata_d = align_rdata_c;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request fields needed after the accept cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
        end else if (accept) begin
            meta_q.off  <= off;
            meta_q.size <= req_size;
            meta_q.uns  <= req_unsigned;
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Second-access copies and the first read word of a split load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_q  <= 1'b0;
            we_q     <= 1'b0;
            w1_q     <= '0;
            wem_hi_q <= 4'b0000;
            din_hi_q <= 32'h0;
            lo_q     <= 32'h0;
        end else begin
            if (accept) begin
                split_q  <= misal;
                we_q     <= req_we;
                w1_q     <= AW'(widx + 32'd1);
                wem_hi_q <= sh_mask[7:4];
                din_hi_q <= sh_data[63:32];
            end
            if (state_q == ST_ACC2) begin
                lo_q <= ram_dout;
            end
        end
    end
`endif

    // Held response; ram_dout may change after capture, rsp_rdata may not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (rsp_load) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end else if ((state_q == ST_RSP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_ram_bridge.sv
// Directed bench for lsu_ram_bridge with a behavioural one-cycle-latency RAM.
module tb_lsu_ram_bridge;

    localparam int unsigned AW = 11;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_en;
    logic          ram_we;
    logic [3:0]    ram_wem;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;

    int checks;
    int errors;

    // Per-request observations.
    int            en_cnt;
    logic [AW-1:0] r_addr [4];
    logic          r_we   [4];
    logic [3:0]    r_wem  [4];
    logic [31:0]   r_din  [4];
    int            lat;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_stable;
    logic          r_rdy_seen;
    logic          post_valid;
    logic          post_ready;

    lsu_ram_bridge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_wem      (ram_wem),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port B model; scramble makes idle-cycle read data change.
    logic [31:0] mem [0:2047];
    logic [31:0] dout_q;
    logic        scramble;
    assign ram_dout = dout_q;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
                end
            end else begin
                dout_q <= mem[ram_addr];
            end
        end else if (scramble) begin
            dout_q <= $urandom;
        end
    end

    task automatic record_ram();
        if (ram_en) begin
            if (en_cnt < 4) begin
                r_addr[en_cnt] = ram_addr;
                r_we[en_cnt]   = ram_we;
                r_wem[en_cnt]  = ram_wem;
                r_din[en_cnt]  = ram_din;
            end
            en_cnt++;
        end
    endtask

    task automatic clear_req();
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
    endtask

    // Issue one request, record RAM activity, latency and response, then handshake.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int hold);
        int n;
        en_cnt     = 0;
        r_stable   = 1'b1;
        r_rdy_seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%h got req_ready=0 expected 1", addr);
        end
        #1 record_ram();
        @(negedge clk);
        clear_req();
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            #1 record_ram();
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout addr=%h got rsp_valid=0 expected 1", addr);
        end
        #1 record_ram();
        r_rdata = rsp_rdata;
        r_err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_rdata !== r_rdata) r_stable = 1'b0;
            if (req_ready) r_rdy_seen = 1'b1;
            #1 record_ram();
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready  = 1'b0;
        post_valid = rsp_valid;
        post_ready = req_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b0; scramble = 1'b0;
        clear_req();
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h10; req_size = 2'd2;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b expected 0", req_ready); end
        checks++; if ({ram_en, ram_we, ram_wem, ram_addr, ram_din} !== '0) begin errors++; $display("FAIL rst_ram got en=%b we=%b wem=%h addr=%h din=%h expected all 0", ram_en, ram_we, ram_wem, ram_addr, ram_din); end
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin errors++; $display("FAIL rst_rsp got v=%b e=%b d=%h expected 0", rsp_valid, rsp_err, rsp_rdata); end
        clear_req();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b expected 1", req_ready); end
    endtask

    task automatic test_word();
        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0);
        checks++; if (en_cnt !== 1) begin errors++; $display("FAIL sw_en_cnt got %0d expected 1", en_cnt); end
        checks++; if ({r_we[0], r_wem[0], r_addr[0]} !== {1'b1, 4'hF, 11'd4}) begin errors++; $display("FAIL sw_port got we=%b wem=%h addr=%0d expected 1 f 4", r_we[0], r_wem[0], r_addr[0]); end
        checks++; if (r_din[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_din got %h expected deadbeef", r_din[0]); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL sw_lat got %0d expected 1", lat); end
        checks++; if ({r_err, r_rdata} !== 33'h0) begin errors++; $display("FAIL sw_rsp got e=%b d=%h expected 0 0", r_err, r_rdata); end
        checks++; if ({post_valid, post_ready} !== 2'b01) begin errors++; $display("FAIL sw_post got v=%b r=%b expected 0 1", post_valid, post_ready); end
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
        checks++; if ({en_cnt, r_we[0], r_addr[0]} !== {32'd1, 1'b0, 11'd4}) begin errors++; $display("FAIL lw_port got cnt=%0d we=%b addr=%0d expected 1 0 4", en_cnt, r_we[0], r_addr[0]); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_lat got %0d expected 2", lat); end
        checks++; if ({r_err, r_rdata} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL lw_rdata got e=%b d=%h expected 0 deadbeef", r_err, r_rdata); end
    endtask

    task automatic test_byte_half();
        do_req(1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080, 0);
        checks++; if ({r_wem[0], r_addr[0]} !== {4'b1000, 11'd4}) begin errors++; $display("FAIL sb_port got wem=%b addr=%0d expected 1000 4", r_wem[0], r_addr[0]); end
        checks++; if (r_din[0][31:24] !== 8'h80) begin errors++; $display("FAIL sb_din got %h expected 80 in lane 3", r_din[0]); end
        do_req(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0);
        checks++; if (r_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h expected ffffff80", r_rdata); end
        do_req(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0);
        checks++; if (r_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu got %h expected 00000080", r_rdata); end
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
        checks++; if (r_rdata !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_after_sb got %h expected 80adbeef", r_rdata); end
        do_req(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 0);
        checks++; if (r_rdata !== 32'hFFFF80AD) begin errors++; $display("FAIL lh got %h expected ffff80ad", r_rdata); end
        do_req(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 0);
        checks++; if (r_rdata !== 32'h000080AD) begin errors++; $display("FAIL lhu got %h expected 000080ad", r_rdata); end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_SPLIT_EN
        do_req(1'b1, 32'h22, 2'd2, 1'b0, 32'h11223344, 0);
        checks++; if (en_cnt !== 2) begin errors++; $display("FAIL ssw_en_cnt got %0d expected 2", en_cnt); end
        checks++; if ({r_addr[0], r_wem[0], r_din[0][31:16]} !== {11'd8, 4'b1100, 16'h3344}) begin errors++; $display("FAIL ssw_first got addr=%0d wem=%b din=%h expected 8 1100 3344xxxx", r_addr[0], r_wem[0], r_din[0]); end
        checks++; if ({r_addr[1], r_wem[1], r_we[1], r_din[1][15:0]} !== {11'd9, 4'b0011, 1'b1, 16'h1122}) begin errors++; $display("FAIL ssw_second got addr=%0d wem=%b we=%b din=%h expected 9 0011 1 xxxx1122", r_addr[1], r_wem[1], r_we[1], r_din[1]); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL ssw_lat got %0d expected 2", lat); end
        do_req(1'b0, 32'h22, 2'd2, 1'b0, 32'h0, 0);
        checks++; if ({en_cnt, r_addr[0], r_addr[1]} !== {32'd2, 11'd8, 11'd9}) begin errors++; $display("FAIL slw_port got cnt=%0d a0=%0d a1=%0d expected 2 8 9", en_cnt, r_addr[0], r_addr[1]); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL slw_lat got %0d expected 3", lat); end
        checks++; if ({r_err, r_rdata} !== {1'b0, 32'h11223344}) begin errors++; $display("FAIL slw_rdata got e=%b d=%h expected 0 11223344", r_err, r_rdata); end
        do_req(1'b0, 32'h1FFD, 2'd2, 1'b0, 32'h0, 0);
        checks++; if ({en_cnt, r_err, lat} !== {32'd0, 1'b1, 32'd1}) begin errors++; $display("FAIL split_oob got cnt=%0d err=%b lat=%0d expected 0 1 1", en_cnt, r_err, lat); end
`else
        do_req(1'b0, 32'h3, 2'd1, 1'b0, 32'h0, 0);
        checks++; if (en_cnt !== 0) begin errors++; $display("FAIL mis_en_cnt got %0d expected 0", en_cnt); end
        checks++; if ({r_err, r_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mis_rsp got e=%b d=%h expected 1 0", r_err, r_rdata); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL mis_lat got %0d expected 1", lat); end
        do_req(1'b1, 32'h21, 2'd2, 1'b0, 32'h55555555, 0);
        checks++; if ({en_cnt, r_err} !== {32'd0, 1'b1}) begin errors++; $display("FAIL mis_sw got cnt=%0d err=%b expected 0 1", en_cnt, r_err); end
`endif
    endtask

    task automatic test_errors();
        do_req(1'b0, 32'h2000, 2'd2, 1'b0, 32'h0, 0);
        checks++; if ({en_cnt, r_err, r_rdata, lat} !== {32'd0, 1'b1, 32'h0, 32'd1}) begin errors++; $display("FAIL oob got cnt=%0d err=%b d=%h lat=%0d expected 0 1 0 1", en_cnt, r_err, r_rdata, lat); end
        do_req(1'b1, 32'h0, 2'd3, 1'b0, 32'h12345678, 0);
        checks++; if ({en_cnt, r_err, lat} !== {32'd0, 1'b1, 32'd1}) begin errors++; $display("FAIL size3 got cnt=%0d err=%b lat=%0d expected 0 1 1", en_cnt, r_err, lat); end
        do_req(1'b0, 32'h1FFC, 2'd2, 1'b0, 32'h0, 0);
        checks++; if ({en_cnt, r_addr[0], r_err} !== {32'd1, 11'd2047, 1'b0}) begin errors++; $display("FAIL last_word got cnt=%0d addr=%0d err=%b expected 1 2047 0", en_cnt, r_addr[0], r_err); end
    endtask

    task automatic test_hold();
        scramble = 1'b1;
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5);
        scramble = 1'b0;
        checks++; if (r_rdata !== 32'h80ADBEEF) begin errors++; $display("FAIL hold_rdata got %h expected 80adbeef", r_rdata); end
        checks++; if (r_stable !== 1'b1) begin errors++; $display("FAIL hold_stable got %b expected 1", r_stable); end
        checks++; if (r_rdy_seen !== 1'b0) begin errors++; $display("FAIL hold_req_ready got %b expected 0", r_rdy_seen); end
        checks++; if (en_cnt !== 1) begin errors++; $display("FAIL hold_en_cnt got %0d expected 1", en_cnt); end
        checks++; if ({post_valid, post_ready} !== 2'b01) begin errors++; $display("FAIL hold_post got v=%b r=%b expected 0 1", post_valid, post_ready); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_wdata = 32'hCAFEF00D;
`ifdef LSU_MISALIGN_SPLIT_EN
        req_addr = 32'h26;
        @(negedge clk);
        clear_req();
`else
        req_addr = 32'h10;
`endif
        #1;
        checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL pre_rst_en got %b expected 1", ram_en); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ram_en, ram_we, ram_wem, ram_addr, ram_din} !== '0) begin errors++; $display("FAIL midrst_ram got en=%b we=%b wem=%h addr=%h din=%h expected all 0", ram_en, ram_we, ram_wem, ram_addr, ram_din); end
        checks++; if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== '0) begin errors++; $display("FAIL midrst_rsp got r=%b v=%b e=%b d=%h expected 0", req_ready, rsp_valid, rsp_err, rsp_rdata); end
        clear_req();
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
        checks++; if ({r_rdata, lat} !== {32'h80ADBEEF, 32'd2}) begin errors++; $display("FAIL post_rst_lw got d=%h lat=%0d expected 80adbeef 2", r_rdata, lat); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        dout_q = 32'h0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_byte_half();
        test_misalign();
        test_errors();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ram_bridge.md
# lsu_ram_bridge

Load/store bridge between the core's memory-access stage and port B of the 32-bit dual-port data/instruction RAM. It converts a single valid/ready byte-addressed request into word-indexed RAM accesses. Accesses are byte, halfword or word, with byte-lane write strobes and sign- or zero-extended load data. It captures the RAM's one-cycle-latency read data into a held response register, because the RAM output is not guaranteed stable.

## Interface
- `RAM_DEPTH`, 2048: RAM depth in 32-bit words; `AW = clogb2(RAM_DEPTH-1)`.
- `BASE_ADDR`, 32'h0000_0000: byte base of the RAM window; must be 4·RAM_DEPTH aligned.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge accepts request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`  in  1  zero-extend load (LBU/LHU).
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  access fault (range, size, misalign).
- `ram_en`  out  1  RAM port B enable.
- `ram_we`  out  1  RAM port B write enable.
- `ram_wem`  out  4  byte write strobes.
- `ram_addr`  out  AW  word index.
- `ram_din`  out  32  lane-aligned write data.
- `ram_dout`  in  32  RAM read data, valid the cycle after a read enable.

## Operation
- States: IDLE, ACC2 (second access of a split), RDW (capture read data), RSP (response held).
- Reset: state IDLE; all outputs 0, including `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err` and all `ram_*`. Reset mid-operation abandons the access. A partially written split store may leave only the first word updated.
- `req_ready` = 1 only in IDLE with `rst_n` high. Accept = `req_valid & req_ready`.
- Offset `o = req_addr[1:0]`. Lane mask `m` = 4'b0001, 4'b0011 or 4'b1111 by size. Shifted mask is `m << o` (8 bits); shifted data is `req_wdata << 8·o` (64 bits).
- Misaligned: word with `o != 0`, or half with `o == 3`. Word index `w = (req_addr - BASE_ADDR) >> 2`.
- Error conditions: `req_size == 3`; `w >= RAM_DEPTH`; split whose `w+1 >= RAM_DEPTH`; misaligned access without split support. On error: no RAM access, RSP entered next cycle, `rsp_err = 1`, `rsp_rdata = 0`.
- Accept cycle, combinational drive:
  - `ram_en = 1`, `ram_addr = w`, `ram_we = req_we`.
  - `ram_wem` = low 4 bits of the shifted mask.
  - `ram_din` = low word of the shifted data.
- Split accesses go to ACC2 and drive `w+1`, upper mask nibble, and the upper data word from registered copies.
- Loads: the word(s) read are concatenated {second, first}, shifted right by 8·o, then sign- or zero-extended per size and `req_unsigned`.
- Stores: no RDW; RSP with `rsp_rdata = 0`.
- RSP: `rsp_valid = 1`; `rsp_rdata` and `rsp_err` are stable until `rsp_valid & rsp_ready`, then IDLE.

## Timing
Accept at cycle N.
- Aligned load: RAM read at N, `ram_dout` sampled at N+1, `rsp_valid` from N+2.
- Aligned store: RAM write at the end of N, `rsp_valid` from N+1.
- Split load: reads at N and N+1, `rsp_valid` from N+3. Split store: writes at N and N+1, `rsp_valid` from N+2.
- Error: `rsp_valid` from N+1.
- One idle cycle after the response handshake before the next accept. `ram_en = 0` in every cycle not listed above.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: misaligned accesses split into two consecutive RAM accesses as above.
- Undefined: ACC2 is not built, and any misaligned access returns `rsp_err = 1` with no RAM access.

## Structure
- Shared package/defines hold:
  - size encodings (`SIZE_B`/`SIZE_H`/`SIZE_W`);
  - state encodings;
  - the `clogb2` function shared with the RAM.
- One sub-module, `lsu_load_align`: a combinational shift/extend from {hi, lo, offset, size, unsigned} to rdata. It is reused by the instruction-side path later.

## Test plan
- Store word 32'hDEADBEEF at BASE+0x10, then load word BASE+0x10 -> `ram_wem` = 4'hF, `ram_addr` = 4; load `rsp_rdata` = 32'hDEADBEEF at N+2.
- Store byte 8'h80 at BASE+0x13, then LB and LBU at the same address -> `ram_wem` = 4'b1000; LB returns 32'hFFFFFF80, LBU returns 32'h00000080.
- With the macro, store word 32'h11223344 at BASE+0x22 -> two writes: word 8 with mask 4'b1100, then word 9 with mask 4'b0011. A following load word BASE+0x22 returns 32'h11223344 at N+3.
- Without the macro, load half BASE+0x3 -> no `ram_en`, `rsp_err` = 1 at N+1.
- Load at BASE + 4·RAM_DEPTH, and `req_size` = 3 -> `rsp_err` = 1, no RAM access.
- Hold `rsp_ready` = 0 for 5 cycles after a load while toggling `ram_dout` -> `rsp_rdata` stays constant and `req_ready` stays 0; after the handshake, IDLE one cycle later. Pulse `rst_n` low mid-split -> all outputs 0 immediately.
